// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// ----------------
// Shares one single-port RAM between two requesters. Port A (CPU) has fixed
// priority. Port B (DMA) is protected by a starvation counter: once B has been
// refused STARVE_LIMIT consecutive cycles while requesting, B wins the next
// cycle. At most one access is granted per cycle, and the grant is
// combinational (zero latency). Read data returns with the RAM's one-cycle
// latency and is qualified by a per-port RdValid.
//
// Ports
//   Clk, Rst_n                     clock (rising edge), synchronous active-low reset
//   A_Req/A_We/A_Addr/A_WrData     port A request, held until A_Gnt is sampled high
//   A_Gnt                          port A access accepted this cycle
//   A_RdValid/A_RdData             port A read return (one cycle after grant)
//   B_*                            same set for port B
//   Ram_Addr/Ram_WrData/Ram_We     RAM command, follows the winning port
//   Ram_RdData                     RAM read data, one cycle after address
module ram_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              A_Req,
    input  logic              A_We,
    input  logic [ADDR_W-1:0] A_Addr,
    input  logic [DATA_W-1:0] A_WrData,
    output logic              A_Gnt,
    output logic              A_RdValid,
    output logic [DATA_W-1:0] A_RdData,
    input  logic              B_Req,
    input  logic              B_We,
    input  logic [ADDR_W-1:0] B_Addr,
    input  logic [DATA_W-1:0] B_WrData,
    output logic              B_Gnt,
    output logic              B_RdValid,
    output logic [DATA_W-1:0] B_RdData,
    output logic [ADDR_W-1:0] Ram_Addr,
    output logic [DATA_W-1:0] Ram_WrData,
    output logic              Ram_We,
    input  logic [DATA_W-1:0] Ram_RdData
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // last_owner: observability only, never feeds arbitration
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } owner_e;

    owner_e      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]  rd_owner_q, rd_owner_d;
    logic        a_gnt_s, b_gnt_s, starved_s;

    // Grant decision; both grants are forced low while reset is asserted
    always_comb begin
        a_gnt_s   = 1'b0;
        b_gnt_s   = 1'b0;
        starved_s = (wait_cnt_q == LIMIT);
        if (Rst_n) begin
            if (B_Req && (!A_Req || starved_s)) begin
                b_gnt_s = 1'b1;
            end else if (A_Req) begin
                a_gnt_s = 1'b1;
            end else begin
                a_gnt_s = 1'b0;
                b_gnt_s = 1'b0;
            end
        end else begin
            a_gnt_s = 1'b0;
            b_gnt_s = 1'b0;
        end
    end

    // RAM command mux; with no winner the address parks on port A, write off
    always_comb begin
        Ram_Addr   = A_Addr;
        Ram_WrData = A_WrData;
        Ram_We     = 1'b0;
        if (b_gnt_s) begin
            Ram_Addr   = B_Addr;
            Ram_WrData = B_WrData;
            Ram_We     = B_We;
        end else if (a_gnt_s) begin
            Ram_Addr   = A_Addr;
            Ram_WrData = A_WrData;
            Ram_We     = A_We;
        end else begin
            Ram_We     = 1'b0;
        end
    end

    // Starvation counter: counts consecutive refused B cycles, saturating
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (b_gnt_s || !B_Req) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q < LIMIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Read-return tag: remembers which port won a read this cycle
    always_comb begin
        rd_owner_d = {b_gnt_s & ~B_We, a_gnt_s & ~A_We};
    end

    // Owner FSM next state: the current winner, or IDLE; illegal codes recover to IDLE
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE, OWN_A, OWN_B: begin
                if (b_gnt_s) begin
                    state_d = OWN_B;
                end else if (a_gnt_s) begin
                    state_d = OWN_A;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            rd_owner_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign A_Gnt     = a_gnt_s;
    assign B_Gnt     = b_gnt_s;
    assign A_RdValid = rd_owner_q[0];
    assign B_RdValid = rd_owner_q[1];
    // Shared return bus: each port qualifies it with its own RdValid
    assign A_RdData  = Ram_RdData;
    assign B_RdData  = Ram_RdData;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a behavioural one-cycle-latency RAM, a table of
// per-cycle vectors with hand-computed expectations, and a hand-written
// sequence for reset landing on a granted read.
module tb_ram_port_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        A_Req, A_We, B_Req, B_We;
    logic [15:0] A_Addr, A_WrData, B_Addr, B_WrData;
    logic        A_Gnt, A_RdValid, B_Gnt, B_RdValid;
    logic [15:0] A_RdData, B_RdData;
    logic [15:0] Ram_Addr, Ram_WrData, Ram_RdData;
    logic        Ram_We;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:255];

    always #5 Clk = ~Clk;

    ram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(3)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .A_Req(A_Req), .A_We(A_We), .A_Addr(A_Addr), .A_WrData(A_WrData),
        .A_Gnt(A_Gnt), .A_RdValid(A_RdValid), .A_RdData(A_RdData),
        .B_Req(B_Req), .B_We(B_We), .B_Addr(B_Addr), .B_WrData(B_WrData),
        .B_Gnt(B_Gnt), .B_RdValid(B_RdValid), .B_RdData(B_RdData),
        .Ram_Addr(Ram_Addr), .Ram_WrData(Ram_WrData), .Ram_We(Ram_We),
        .Ram_RdData(Ram_RdData)
    );

    // Single-port RAM model, read-before-write, one-cycle read latency
    always @(posedge Clk) begin
        if (Ram_We) mem[Ram_Addr[7:0]] <= Ram_WrData;
        Ram_RdData <= mem[Ram_Addr[7:0]];
    end

    typedef struct {
        logic        rst_n;
        logic        a_req, a_we;
        logic [15:0] a_addr, a_wd;
        logic        b_req, b_we;
        logic [15:0] b_addr, b_wd;
        logic        e_agnt, e_bgnt, e_rwe, e_ardv, e_brdv;
        logic [15:0] e_rd;
    } vec_t;

    localparam int NV = 30;
    vec_t tbl [NV];

    function automatic vec_t mk(logic r, logic ar, logic aw, logic [15:0] aa, logic [15:0] ad,
                                logic br, logic bw, logic [15:0] ba, logic [15:0] bd,
                                logic eag, logic ebg, logic erwe, logic eard, logic ebrd,
                                logic [15:0] erd);
        vec_t v;
        v.rst_n = r;  v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wd = ad;
        v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wd = bd;
        v.e_agnt = eag; v.e_bgnt = ebg; v.e_rwe = erwe;
        v.e_ardv = eard; v.e_brdv = ebrd; v.e_rd = erd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic ar, input logic aw, input logic [15:0] aa,
                         input logic [15:0] ad, input logic br, input logic bw,
                         input logic [15:0] ba, input logic [15:0] bd);
        @(negedge Clk);
        Rst_n = r; A_Req = ar; A_We = aw; A_Addr = aa; A_WrData = ad;
        B_Req = br; B_We = bw; B_Addr = ba; B_WrData = bd;
        #2;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
        mem[16'h10] = 16'hBEEF;

        //                 rst ar aw aaddr     awd       br bw baddr     bwd       ag bg we ar br rd
        tbl[0]  = mk(1'b0,1'b1,1'b1,16'h0020,16'h5555,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000);
        tbl[1]  = mk(1'b0,1'b1,1'b1,16'h0020,16'h5555,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000);
        tbl[2]  = mk(1'b1,1'b1,1'b0,16'h0010,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000);
        tbl[3]  = mk(1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b1,1'b0,16'hBEEF);
        tbl[4]  = mk(1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b1,16'h0040,16'h1234,1'b0,1'b1,1'b1,1'b0,1'b0,16'h0000);
        tbl[5]  = mk(1'b1,1'b1,1'b0,16'h0040,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000);
        tbl[6]  = mk(1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b1,1'b0,16'h1234);
        // starvation: A,A,A,B,A,A,A,B
        tbl[7]  = mk(1'b1,1'b1,1'b0,16'h0001,16'h0000,1'b1,1'b0,16'h0080,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000);
        tbl[8]  = mk(1'b1,1'b1,1'b0,16'h0002,16'h0000,1'b1,1'b0,16'h0080,16'h0000,1'b1,1'b0,1'b0,1'b1,1'b0,16'hA001);
        tbl[9]  = mk(1'b1,1'b1,1'b0,16'h0003,16'h0000,1'b1,1'b0,16'h0080,16'h0000,1'b1,1'b0,1'b0,1'b1,1'b0,16'hA002);
        tbl[10] = mk(1'b1,1'b1,1'b0,16'h0004,16'h0000,1'b1,1'b0,16'h0080,16'h0000,1'b0,1'b1,1'b0,1'b1,1'b0,16'hA003);
        tbl[11] = mk(1'b1,1'b1,1'b0,16'h0004,16'h0000,1'b1,1'b0,16'h0081,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b1,16'hA080);
        tbl[12] = mk(1'b1,1'b1,1'b0,16'h0005,16'h0000,1'b1,1'b0,16'h0081,16'h0000,1'b1,1'b0,1'b0,1'b1,1'b0,16'hA004);
        tbl[13] = mk(1'b1,1'b1,1'b0,16'h0006,16'h0000,1'b1,1'b0,16'h0081,16'h0000,1'b1,1'b0,1'b0,1'b1,1'b0,16'hA005);
        tbl[14] = mk(1'b1,1'b1,1'b0,16'h0007,16'h0000,1'b1,1'b0,16'h0081,16'h0000,1'b0,1'b1,1'b0,1'b1,1'b0,16'hA006);
        tbl[15] = mk(1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b1,16'hA081);
        // B drops after two refusals: counter must restart from zero
        tbl[16] = mk(1'b1,1'b1,1'b0,16'h0008,16'h0000,1'b1,1'b0,16'h0082,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000);
        tbl[17] = mk(1'b1,1'b1,1'b0,16'h0009,16'h0000,1'b1,1'b0,16'h0082,16'h0000,1'b1,1'b0,1'b0,1'b1,1'b0,16'hA008);
        tbl[18] = mk(1'b1,1'b1,1'b0,16'h000A,16'h0000,1'b0,1'b0,16'h0082,16'h0000,1'b1,1'b0,1'b0,1'b1,1'b0,16'hA009);
        tbl[19] = mk(1'b1,1'b1,1'b0,16'h000B,16'h0000,1'b1,1'b0,16'h0082,16'h0000,1'b1,1'b0,1'b0,1'b1,1'b0,16'hA00A);
        tbl[20] = mk(1'b1,1'b1,1'b0,16'h000C,16'h0000,1'b1,1'b0,16'h0082,16'h0000,1'b1,1'b0,1'b0,1'b1,1'b0,16'hA00B);
        tbl[21] = mk(1'b1,1'b1,1'b0,16'h000D,16'h0000,1'b1,1'b0,16'h0082,16'h0000,1'b1,1'b0,1'b0,1'b1,1'b0,16'hA00C);
        tbl[22] = mk(1'b1,1'b1,1'b0,16'h000E,16'h0000,1'b1,1'b0,16'h0082,16'h0000,1'b0,1'b1,1'b0,1'b1,1'b0,16'hA00D);
        // one-cycle B pulse while A holds the bus
        tbl[23] = mk(1'b1,1'b1,1'b0,16'h000E,16'h0000,1'b1,1'b0,16'h0083,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b1,16'hA082);
        tbl[24] = mk(1'b1,1'b1,1'b0,16'h000F,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,1'b0,1'b1,1'b0,16'hA00E);
        tbl[25] = mk(1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b1,1'b0,16'hA00F);
        // A write, then B reads it back
        tbl[26] = mk(1'b1,1'b1,1'b1,16'h0030,16'h7777,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000);
        tbl[27] = mk(1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000);
        tbl[28] = mk(1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,16'h0030,16'h0000,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000);
        tbl[29] = mk(1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b1,16'h7777);

        Rst_n = 1'b0; A_Req = 1'b1; A_We = 1'b1; A_Addr = 16'h0020; A_WrData = 16'h5555;
        B_Req = 1'b0; B_We = 1'b0; B_Addr = 16'h0000; B_WrData = 16'h0000;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst_n, tbl[i].a_req, tbl[i].a_we, tbl[i].a_addr, tbl[i].a_wd,
                  tbl[i].b_req, tbl[i].b_we, tbl[i].b_addr, tbl[i].b_wd);
            chk($sformatf("v%0d A_Gnt", i), 16'(A_Gnt), 16'(tbl[i].e_agnt));
            chk($sformatf("v%0d B_Gnt", i), 16'(B_Gnt), 16'(tbl[i].e_bgnt));
            chk($sformatf("v%0d Ram_We", i), 16'(Ram_We), 16'(tbl[i].e_rwe));
            chk($sformatf("v%0d A_RdValid", i), 16'(A_RdValid), 16'(tbl[i].e_ardv));
            chk($sformatf("v%0d B_RdValid", i), 16'(B_RdValid), 16'(tbl[i].e_brdv));
            if (tbl[i].e_ardv) chk($sformatf("v%0d A_RdData", i), A_RdData, tbl[i].e_rd);
            if (tbl[i].e_brdv) chk($sformatf("v%0d B_RdData", i), B_RdData, tbl[i].e_rd);
            if (tbl[i].e_bgnt || tbl[i].e_agnt)
                chk($sformatf("v%0d Ram_Addr", i), Ram_Addr,
                    tbl[i].e_bgnt ? tbl[i].b_addr : tbl[i].a_addr);
        end

        // Reset lands on the edge ending a granted A read, with B's counter at 2
        drive(1'b1, 1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 1'b0, 16'h0090, 16'h0000);
        chk("mr pre1 A_Gnt", 16'(A_Gnt), 16'd1);
        drive(1'b1, 1'b1, 1'b0, 16'h0012, 16'h0000, 1'b1, 1'b0, 16'h0090, 16'h0000);
        chk("mr pre2 A_Gnt", 16'(A_Gnt), 16'd1);
        drive(1'b1, 1'b1, 1'b0, 16'h0013, 16'h0000, 1'b1, 1'b0, 16'h0090, 16'h0000);
        chk("mr grant A_Gnt", 16'(A_Gnt), 16'd1);
        Rst_n = 1'b0;
        #1;
        chk("mr gated A_Gnt", 16'(A_Gnt), 16'd0);
        chk("mr gated B_Gnt", 16'(B_Gnt), 16'd0);
        // after reset both request: counter restarted, so A,A,A,B
        drive(1'b1, 1'b1, 1'b0, 16'h0014, 16'h0000, 1'b1, 1'b0, 16'h0090, 16'h0000);
        chk("mr post A_RdValid", 16'(A_RdValid), 16'd0);
        chk("mr post B_RdValid", 16'(B_RdValid), 16'd0);
        chk("mr c1 A_Gnt", 16'(A_Gnt), 16'd1);
        drive(1'b1, 1'b1, 1'b0, 16'h0015, 16'h0000, 1'b1, 1'b0, 16'h0090, 16'h0000);
        chk("mr c2 A_Gnt", 16'(A_Gnt), 16'd1);
        chk("mr c2 A_RdData", A_RdData, 16'hA014);
        drive(1'b1, 1'b1, 1'b0, 16'h0016, 16'h0000, 1'b1, 1'b0, 16'h0090, 16'h0000);
        chk("mr c3 A_Gnt", 16'(A_Gnt), 16'd1);
        drive(1'b1, 1'b1, 1'b0, 16'h0017, 16'h0000, 1'b1, 1'b0, 16'h0090, 16'h0000);
        chk("mr c4 B_Gnt", 16'(B_Gnt), 16'd1);
        chk("mr c4 A_Gnt", 16'(A_Gnt), 16'd0);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("mr c5 B_RdValid", 16'(B_RdValid), 16'd1);
        chk("mr c5 B_RdData", B_RdData, 16'hA090);
        chk("mr c5 A_RdValid", 16'(A_RdValid), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
